// File: rtl/multiport_ram_pkg.sv
// Shared definitions for the multiport RAM: FSM encoding and port-slicing helpers.
package multiport_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Low bit of port `port` inside a flattened per-port bus of `width` bits.
    function automatic int port_lo(input int port, input int width);
        return port * width;
    endfunction

    // Priority distance of port idx from the round-robin pointer; smaller wins.
    function automatic int rr_dist(input int idx, input int rr, input int n);
        return (idx + n - rr) % n;
    endfunction

endpackage

// File: rtl/mpram_wr_arbiter.sv
// Same-address write arbiter: pairwise address compare, rotating priority,
// and the round-robin pointer that advances on every conflict cycle.
module mpram_wr_arbiter
    import multiport_ram_pkg::*;
#(
    parameter int N_PORTS = 8,
    parameter int ADDR_W  = 9
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        active,
    input  logic [N_PORTS-1:0]          write_en,
    input  logic [N_PORTS*ADDR_W-1:0]   addr,
    output logic [N_PORTS-1:0]          write_ack,
    output logic                        conflict
);
    localparam int RR_W = $clog2(N_PORTS);

    logic [RR_W-1:0] rr;
    logic            win;

    // A requester wins unless some other requester on its address is closer to rr.
    always_comb begin
        write_ack = '0;
        conflict  = 1'b0;
        win       = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (active && write_en[i]) begin
                win = 1'b1;
                for (int j = 0; j < N_PORTS; j++) begin
                    if (j != i && write_en[j] &&
                        addr[port_lo(j, ADDR_W) +: ADDR_W] == addr[port_lo(i, ADDR_W) +: ADDR_W]) begin
                        conflict = 1'b1;
                        if (rr_dist(j, int'(rr), N_PORTS) < rr_dist(i, int'(rr), N_PORTS))
                            win = 1'b0;
                    end
                end
                write_ack[i] = win;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rr <= '0;
        else if (conflict)
            rr <= (rr == RR_W'(N_PORTS - 1)) ? '0 : rr + RR_W'(1);
    end

endmodule

// File: rtl/multiport_ram.sv
// N-port shared data memory: arbitrated writes, registered read-first reads,
// and an optional post-reset clear sweep gating all port activity.
module multiport_ram
    import multiport_ram_pkg::*;
#(
    parameter int N_PORTS        = 8,
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 9,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PORTS-1:0]          write_en,
    input  logic [N_PORTS-1:0]          read_en,
    input  logic [N_PORTS*ADDR_W-1:0]   addr,
    input  logic [N_PORTS*DATA_W-1:0]   data_in,
    output logic [N_PORTS*DATA_W-1:0]   data_out,
    output logic [N_PORTS-1:0]          read_valid,
    output logic [N_PORTS-1:0]          write_ack,
    output logic                        ready
);
    localparam int DEPTH = 2 ** ADDR_W;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   cnt;
    logic                clearing, running;
    logic                conflict;
    logic [DATA_W-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (clearing)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        if (state == ST_CLEAR && cnt == '1)
            next_state = ST_RUN;
    end

    always_comb begin
        clearing = (state == ST_CLEAR);
        running  = (state == ST_RUN);
        ready    = running;
    end

    mpram_wr_arbiter #(
        .N_PORTS (N_PORTS),
        .ADDR_W  (ADDR_W)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .active    (running),
        .write_en  (write_en),
        .addr      (addr),
        .write_ack (write_ack),
        .conflict  (conflict)
    );

    // A reset cycle commits nothing, even if the arbiter still shows a grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clearing)
                mem[cnt] <= '0;
            else
                for (int i = 0; i < N_PORTS; i++)
                    if (write_ack[i])
                        mem[addr[port_lo(i, ADDR_W) +: ADDR_W]] <= data_in[port_lo(i, DATA_W) +: DATA_W];
        end
    end

    // Non-blocking reads of mem give read-first behaviour against same-edge writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_valid <= '0;
            data_out   <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                read_valid[i] <= running && read_en[i];
                if (running && read_en[i])
                    data_out[port_lo(i, DATA_W) +: DATA_W] <= mem[addr[port_lo(i, ADDR_W) +: ADDR_W]];
            end
        end
    end

endmodule

// File: tb/tb_multiport_ram.sv
// Randomised and directed bench for multiport_ram against a word-array reference model.
module tb_multiport_ram;
    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = 9;
    localparam int DEPTH = 512;

    logic            clk;
    logic            reset;
    logic [N-1:0]    write_en, read_en;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data_in;
    logic [N*DW-1:0] data_out;
    logic [N-1:0]    read_valid, write_ack;
    logic            ready;

    logic            s_reset;
    logic [1:0]      s_we, s_re, s_rv, s_ack;
    logic [7:0]      s_addr;
    logic [63:0]     s_din, s_dout;
    logic            s_ready;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]   m_mem [DEPTH];
    int              m_rr;
    logic [N*DW-1:0] exp_dout;
    logic [N-1:0]    last_ack;

    multiport_ram dut (
        .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en),
        .addr(addr), .data_in(data_in), .data_out(data_out),
        .read_valid(read_valid), .write_ack(write_ack), .ready(ready)
    );

    multiport_ram #(.N_PORTS(2), .DATA_W(32), .ADDR_W(4), .CLEAR_ON_RESET(0)) dut_small (
        .clk(clk), .reset(s_reset), .write_en(s_we), .read_en(s_re),
        .addr(s_addr), .data_in(s_din), .data_out(s_dout),
        .read_valid(s_rv), .write_ack(s_ack), .ready(s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        write_en = '0; read_en = '0; addr = '0; data_in = '0;
    endtask

    task automatic set_port(input int p, input bit we, input bit re,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_en[p] = we;
        read_en[p]  = re;
        addr[p*AW +: AW]    = a;
        data_in[p*DW +: DW] = d;
    endtask

    task automatic model_reset();
        for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
        m_rr = 0;
        exp_dout = '0;
    endtask

    // Each address goes to the first requester met walking upward from rr.
    function automatic logic [N-1:0] model_grant(input logic [N-1:0] we, input logic [N*AW-1:0] a,
                                                 input int rr, output bit conflict);
        logic [N-1:0] g;
        bit taken;
        int p;
        g = '0;
        conflict = 1'b0;
        for (int k = 0; k < N; k++) begin
            p = (rr + k) % N;
            if (we[p]) begin
                taken = 1'b0;
                for (int q = 0; q < N; q++)
                    if (q != p && we[q] && a[q*AW +: AW] == a[p*AW +: AW]) begin
                        conflict = 1'b1;
                        if (g[q]) taken = 1'b1;
                    end
                if (!taken) g[p] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic run_cycle();
        logic [N-1:0] g, exp_rv;
        bit c;
        g = model_grant(write_en, addr, m_rr, c);
        #1;
        total++;
        if (write_ack !== g) begin
            bad++;
            $display("FAIL write_ack got=%b exp=%b", write_ack, g);
        end
        last_ack = write_ack;
        for (int p = 0; p < N; p++)
            if (read_en[p]) exp_dout[p*DW +: DW] = m_mem[addr[p*AW +: AW]];
        exp_rv = read_en;
        for (int p = 0; p < N; p++)
            if (g[p]) m_mem[addr[p*AW +: AW]] = data_in[p*DW +: DW];
        if (c) m_rr = (m_rr + 1) % N;
        @(posedge clk); #1;
        total++;
        if (read_valid !== exp_rv) begin
            bad++;
            $display("FAIL read_valid got=%b exp=%b", read_valid, exp_rv);
        end
        total++;
        if (data_out !== exp_dout) begin
            bad++;
            $display("FAIL data_out got=%h exp=%h", data_out, exp_dout);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n != DEPTH) begin
            bad++;
            $display("FAIL %s clear_cycles got=%0d exp=%0d", name, n, DEPTH);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        total++;
        if (ready !== 1'b0 || read_valid !== '0 || data_out !== '0) begin
            bad++;
            $display("FAIL reset_state got=%b/%b/%h exp=0/0/0", ready, read_valid, data_out);
        end
        wait_ready("reset");
    endtask

    task automatic test_idle_reads();
        clear_inputs();
        set_port(0, 0, 1, 9'd0, '0);
        set_port(1, 0, 1, 9'd255, '0);
        set_port(2, 0, 1, 9'd511, '0);
        run_cycle();
        total++;
        if (read_valid !== 8'b0000_0111 || data_out[3*DW-1:0] !== '0) begin
            bad++;
            $display("FAIL idle_reads got=%b/%h exp=00000111/0", read_valid, data_out[3*DW-1:0]);
        end
        clear_inputs();
        run_cycle();
    endtask

    task automatic test_distinct();
        clear_inputs();
        for (int p = 0; p < N; p++) set_port(p, 1, 0, AW'(8*p), DW'(16'h1000 + p));
        run_cycle();
        total++;
        if (last_ack !== 8'hFF) begin
            bad++;
            $display("FAIL distinct_ack got=%b exp=11111111", last_ack);
        end
        clear_inputs();
        for (int p = 0; p < N; p++) set_port(p, 0, 1, AW'(8*p), '0);
        run_cycle();
        for (int p = 0; p < N; p++) begin
            total++;
            if (data_out[p*DW +: DW] !== DW'(16'h1000 + p)) begin
                bad++;
                $display("FAIL distinct_rd port=%0d got=%h exp=%h", p, data_out[p*DW +: DW], 16'h1000 + p);
            end
        end
        clear_inputs();
    endtask

    task automatic test_conflict();
        logic [N-1:0] pending;
        int ack_cyc [N];
        logic [DW-1:0] wdat [N];
        for (int p = 0; p < N; p++) ack_cyc[p] = 0;
        wdat[2] = 16'hAAAA; wdat[5] = 16'hBBBB; wdat[7] = 16'hCCCC;
        pending = 8'b1010_0100;
        for (int cyc = 1; cyc <= 6 && pending != '0; cyc++) begin
            clear_inputs();
            for (int p = 0; p < N; p++)
                if (pending[p]) set_port(p, 1, 0, 9'h040, wdat[p]);
            run_cycle();
            for (int p = 0; p < N; p++)
                if (last_ack[p] && pending[p]) begin
                    ack_cyc[p] = cyc;
                    pending[p] = 1'b0;
                end
        end
        total++;
        if (ack_cyc[2] != 1 || ack_cyc[5] != 2 || ack_cyc[7] != 3) begin
            bad++;
            $display("FAIL conflict_order got=%0d/%0d/%0d exp=1/2/3", ack_cyc[2], ack_cyc[5], ack_cyc[7]);
        end
        // rr should now sit at 2 after two conflict cycles.
        clear_inputs();
        for (int p = 0; p < N; p++) set_port(p, 1, 0, 9'h041, DW'(p));
        run_cycle();
        total++;
        if (last_ack !== 8'b0000_0100) begin
            bad++;
            $display("FAIL conflict_rr got=%b exp=00000100", last_ack);
        end
        clear_inputs();
        set_port(0, 0, 1, 9'h040, '0);
        run_cycle();
        total++;
        if (data_out[DW-1:0] !== 16'hCCCC) begin
            bad++;
            $display("FAIL conflict_final got=%h exp=cccc", data_out[DW-1:0]);
        end
        clear_inputs();
    endtask

    task automatic test_read_during_write();
        clear_inputs();
        set_port(0, 1, 0, 9'h010, 16'h1234);
        run_cycle();
        clear_inputs();
        set_port(1, 0, 1, 9'h010, '0);
        set_port(3, 1, 0, 9'h010, 16'h5678);
        run_cycle();
        total++;
        if (data_out[1*DW +: DW] !== 16'h1234) begin
            bad++;
            $display("FAIL rdw_old got=%h exp=1234", data_out[1*DW +: DW]);
        end
        clear_inputs();
        set_port(1, 0, 1, 9'h010, '0);
        run_cycle();
        total++;
        if (data_out[1*DW +: DW] !== 16'h5678) begin
            bad++;
            $display("FAIL rdw_new got=%h exp=5678", data_out[1*DW +: DW]);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < N; p++)
                set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         AW'($urandom_range(0, 15)), DW'($urandom));
            run_cycle();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        set_port(0, 1, 0, 9'h040, 16'h1111);
        set_port(1, 1, 0, 9'h040, 16'h2222);
        set_port(2, 1, 1, 9'h040, 16'h3333);
        set_port(3, 1, 0, 9'h010, 16'h4444);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_inputs();
        model_reset();
        total++;
        if (ready !== 1'b0 || read_valid !== '0 || data_out !== '0) begin
            bad++;
            $display("FAIL midreset_state got=%b/%b/%h exp=0/0/0", ready, read_valid, data_out);
        end
        wait_ready("midreset");
        set_port(0, 0, 1, 9'h040, '0);
        set_port(1, 0, 1, 9'h010, '0);
        set_port(2, 0, 1, 9'h041, '0);
        set_port(3, 0, 1, 9'h000, '0);
        run_cycle();
        total++;
        if (data_out[4*DW-1:0] !== '0 || read_valid !== 8'b0000_1111) begin
            bad++;
            $display("FAIL midreset_clear got=%h/%b exp=0/00001111", data_out[4*DW-1:0], read_valid);
        end
        clear_inputs();
    endtask

    task automatic test_small();
        logic [31:0] ref_mem [16];
        logic [31:0] d0, d1;
        s_we = '0; s_re = '0; s_addr = '0; s_din = '0;
        s_reset = 1'b1;
        @(posedge clk); #1;
        s_reset = 1'b0;
        total++;
        if (s_ready !== 1'b1 || s_rv !== 2'b00) begin
            bad++;
            $display("FAIL small_ready got=%b/%b exp=1/00", s_ready, s_rv);
        end
        for (int i = 0; i < 8; i++) begin
            d0 = $urandom; d1 = $urandom;
            ref_mem[i] = d0; ref_mem[i+8] = d1;
            s_we = 2'b11;
            s_addr = {4'(i + 8), 4'(i)};
            s_din = {d1, d0};
            #1;
            total++;
            if (s_ack !== 2'b11) begin
                bad++;
                $display("FAIL small_wr_ack addr=%0d got=%b exp=11", i, s_ack);
            end
            @(posedge clk); #1;
        end
        // Two conflict cycles on address 3: port 0 wins first, then port 1.
        s_addr = {4'd3, 4'd3};
        s_din = {32'hBEEF0001, 32'hBEEF0000};
        #1;
        total++;
        if (s_ack !== 2'b01) begin
            bad++;
            $display("FAIL small_conf1 got=%b exp=01", s_ack);
        end
        @(posedge clk); #1;
        total++;
        if (s_ack !== 2'b10) begin
            bad++;
            $display("FAIL small_conf2 got=%b exp=10", s_ack);
        end
        ref_mem[3] = 32'hBEEF0001;
        @(posedge clk); #1;
        s_we = '0;
        for (int i = 0; i < 8; i++) begin
            s_re = 2'b11;
            s_addr = {4'(i + 8), 4'(i)};
            @(posedge clk); #1;
            total++;
            if (s_rv !== 2'b11 || s_dout !== {ref_mem[i+8], ref_mem[i]}) begin
                bad++;
                $display("FAIL small_rd addr=%0d got=%b/%h exp=11/%h", i, s_rv, s_dout, {ref_mem[i+8], ref_mem[i]});
            end
        end
        s_re = '0;
    endtask

    initial begin
        reset = 1'b1;
        s_reset = 1'b1;
        s_we = '0; s_re = '0; s_addr = '0; s_din = '0;
        clear_inputs();
        @(posedge clk); #1;
        test_reset();
        test_idle_reads();
        test_distinct();
        test_conflict();
        test_read_during_write();
        test_random();
        test_reset_mid();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiport_ram.md
# multiport_ram

Parametrised N-port shared data memory for the multicore processor: every core gets its own read/write port on one common word array. Same-address write conflicts are resolved by a round-robin arbiter, with a per-port write acknowledge so losing cores stall and retry. Reads are registered with a valid strobe. An optional clear sequence zeroes the array after reset. It replaces the fixed eight-port RAM, sits between the cores' load/store stages and the shared data space, and is instantiated once per multicore build.

## Interface
Parameters:
- N_PORTS, 8, number of core ports (2..16)
- DATA_W, 16, word width
- ADDR_W, 9, address width; DEPTH = 2**ADDR_W
- CLEAR_ON_RESET, 1, 1 = zero whole array after reset; 0 = no clear

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- write_en  in  N_PORTS  per-port write request
- read_en  in  N_PORTS  per-port read request
- addr  in  N_PORTS*ADDR_W  port i at bits [i*ADDR_W +: ADDR_W]
- data_in  in  N_PORTS*DATA_W  port i write data
- data_out  out  N_PORTS*DATA_W  port i registered read data
- read_valid  out  N_PORTS  one-cycle pulse, data_out[i] updated
- write_ack  out  N_PORTS  combinational grant, write commits at this edge
- ready  out  1  high once clear is done, requests accepted

## Operation
- States: CLEAR, RUN (encoding in package).
- Reset (sampled high) sets the following:
  - state = CLEAR if CLEAR_ON_RESET, else RUN
  - clear counter = 0; rr pointer = 0
  - read_valid = 0; data_out = 0
  - ready = 0 only in CLEAR
- CLEAR:
  - Each cycle writes mem[cnt] = 0 and increments cnt.
  - At cnt == DEPTH-1, goes to RUN.
  - All port requests are ignored: write_ack = 0, read_valid stays 0.
- RUN, writes:
  - A port with write_en=1 and no other requesting port on the same address is granted.
  - For ports sharing an address, exactly one is granted: the first requester found scanning from index rr upward, mod N_PORTS.
  - Granted ports commit mem[addr] = data_in at the edge.
  - Denied ports see write_ack = 0 and must hold their request.
- RUN, rr pointer: advances rr = (rr+1) mod N_PORTS on any cycle with at least one conflict, otherwise holds. A continuously requesting port is therefore granted within N_PORTS-1 conflict cycles.
- RUN, reads:
  - read_en[i] = 1 causes data_out[i] = mem[addr_i] and read_valid[i] = 1 at the next edge.
  - Read-first: a read and a write to the same address in one cycle return the old word.
  - data_out[i] holds its value when read_en[i] = 0.
  - read_en and write_en may both be set on one port; both actions occur, and the read returns the old word.
- Reset mid-operation aborts everything; no pending write is committed that cycle, and the clear restarts from 0.

## Timing
- Read latency is 1 cycle from read_en to read_valid/data_out.
- Back-to-back reads every cycle are supported.
- write_ack is combinational in the request cycle, and the write is visible to reads issued from the next cycle.
- ready rises DEPTH cycles after the first edge with reset low (512 for defaults). With CLEAR_ON_RESET=0, ready is high the cycle after reset.
- Memory contents with CLEAR_ON_RESET=0 are undefined after reset.
- All outputs are registered except write_ack, which is a function of write_en, addr, rr and state.

## Structure
- Package multiport_ram_pkg holds:
  - state encodings ST_CLEAR, ST_RUN
  - index-slicing helper constants
- Sub-module mpram_wr_arbiter, N_PORTS-generic:
  - pairwise address compare
  - rotating-priority grant
  - rr pointer register and conflict flag
- Top level holds the array, read registers, clear FSM and counter.

## Test plan
- Reset then idle:
  - ready is low for 512 cycles, then high.
  - Reads of addresses 0, 255 and 511 return 0x0000 with read_valid one cycle later.
- Distinct-address writes: ports 0..7 write 0x1000+i to addresses 8*i in one cycle. All write_ack are 1, and a readback on all ports next cycle returns each value.
- Conflict: ports 2, 5 and 7 write 0xAAAA, 0xBBBB and 0xCCCC to addr 0x40 with rr=0, holding requests until acked.
  - Cycle 1: port 2 is acked.
  - Cycle 2: port 5 is acked.
  - Cycle 3: port 7 is acked.
  - Final word is 0xCCCC.
  - rr advances on cycles 1 and 2 only (the two conflict cycles).
- Read-during-write: mem[0x10] = 0x1234; port 1 reads 0x10 while port 3 writes 0x5678 there. Port 1 gets 0x1234; a read the next cycle gets 0x5678.
- Reset mid-run: assert reset during a conflicting write burst.
  - No write is committed that cycle.
  - ready drops, and the full clear repeats.
  - Afterwards, previously written addresses read 0x0000.
- Parameter sweep: N_PORTS=2/DATA_W=32/ADDR_W=4 and CLEAR_ON_RESET=0. ready is high one cycle after reset, and a full-depth write then read of 16 addresses is correct.
